// File: rtl/bpuf_crp_controller.sv
// bpuf_crp_controller: sequences clear/excite/sample cycles on a bistable-ring PUF and
// majority-votes synchronized samples into a response word plus instability mask.
module bpuf_crp_controller #(
  parameter int CHAL_W = 10,
  parameter int RESP_BITS = 8,
  parameter logic [CHAL_W-1:0] TAPS = 10'h240,
  parameter int RST_CYC = 4,
  parameter int SETTLE_CYC = 16,
  parameter int NUM_SAMPLES = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CHAL_W-1:0]    req_chal,
  output logic [CHAL_W-1:0]    puf_chal,
  input  logic                 puf_resp,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [RESP_BITS-1:0] rsp_data,
  output logic [RESP_BITS-1:0] rsp_unstable,
  output logic                 busy
);
  localparam int MAXC = RST_CYC > SETTLE_CYC ? (RST_CYC > NUM_SAMPLES ? RST_CYC : NUM_SAMPLES)
                                             : (SETTLE_CYC > NUM_SAMPLES ? SETTLE_CYC : NUM_SAMPLES);
  localparam int PW = $clog2(MAXC) + 1;
  localparam int BW = $clog2(RESP_BITS) + 1;
  localparam int OW = $clog2(NUM_SAMPLES) + 1;
  typedef enum logic [2:0] {IDLE, CLEAR, EXCITE, SAMPLE, DONE} state_t;
  state_t state, state_n;
  logic [PW-1:0] cnt, cnt_n;
  logic [BW-1:0] bit_idx, bit_idx_n;
  logic [OW-1:0] ones, ones_n, ones_fin;
  logic [CHAL_W-1:0] lfsr, lfsr_n;
  logic [RESP_BITS-1:0] data, data_n, unst, unst_n;
  logic s1, s2, maj, flaky;
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign rsp_valid = state == DONE;
  assign rsp_data = data;
  assign rsp_unstable = unst;
  assign ones_fin = ones + OW'(s2);
  assign maj = ones_fin > OW'(NUM_SAMPLES / 2);
  assign flaky = ones_fin != '0 && ones_fin != OW'(NUM_SAMPLES);
  always_comb begin
    state_n = state;
    cnt_n = cnt + PW'(1);
    bit_idx_n = bit_idx;
    ones_n = ones;
    lfsr_n = lfsr;
    data_n = data;
    unst_n = unst;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (req_valid) begin
          lfsr_n = req_chal == '0 ? CHAL_W'(1) : req_chal;
          bit_idx_n = '0;
          data_n = '0;
          unst_n = '0;
          state_n = CLEAR;
        end
      end
      CLEAR: if (cnt == PW'(RST_CYC - 1)) begin
        cnt_n = '0;
        state_n = EXCITE;
      end
      EXCITE: if (cnt == PW'(SETTLE_CYC - 1)) begin
        cnt_n = '0;
        ones_n = '0;
        state_n = SAMPLE;
      end
      SAMPLE: begin
        ones_n = ones_fin;
        if (cnt == PW'(NUM_SAMPLES - 1)) begin
          cnt_n = '0;
          data_n = data | (RESP_BITS'(maj) << bit_idx);
          unst_n = unst | (RESP_BITS'(flaky) << bit_idx);
          if (bit_idx == BW'(RESP_BITS - 1)) state_n = DONE;
          else begin
            bit_idx_n = bit_idx + BW'(1);
            lfsr_n = {lfsr[CHAL_W-2:0], ^(lfsr & TAPS)};
            state_n = CLEAR;
          end
        end
      end
      DONE: begin
        cnt_n = '0;
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // puf_chal is registered from next-state so every challenge is bracketed by CLEAR zeros
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      ones <= '0;
      lfsr <= '0;
      data <= '0;
      unst <= '0;
      s1 <= 1'b0;
      s2 <= 1'b0;
      puf_chal <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_idx_n;
      ones <= ones_n;
      lfsr <= lfsr_n;
      data <= data_n;
      unst <= unst_n;
      s1 <= puf_resp;
      s2 <= s1;
      puf_chal <= (state_n == EXCITE || state_n == SAMPLE) ? lfsr_n : '0;
    end
  end
endmodule

// File: tb/tb_bpuf_crp_controller.sv
// tb_bpuf_crp_controller: directed and randomized exchanges checked against a
// cycle-table reference model of the challenge schedule and majority vote.
module tb_bpuf_crp_controller;
  localparam int RB = 8, PER = 25, LAT = 200;
  logic clk = 0, rst_n = 0, req_valid = 0, rsp_ready = 0, puf_resp = 0;
  logic [9:0] req_chal = '0;
  logic req_ready, rsp_valid, busy;
  logic [9:0] puf_chal;
  logic [RB-1:0] rsp_data, rsp_unstable;
  int compared = 0, mismatched = 0;
  logic pr [LAT];

  bpuf_crp_controller dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_chal(req_chal), .puf_chal(puf_chal), .puf_resp(puf_resp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_unstable(rsp_unstable), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: per-bit biased random, 1: all ones, 2: all zeros
  task automatic fill(input int mode);
    int thr;
    thr = 0;
    for (int t = 0; t < LAT; t++) begin
      if (t % PER == 0) thr = $urandom_range(0, 10);
      pr[t] = mode == 1 ? 1'b1 : mode == 2 ? 1'b0 : ($urandom_range(0, 9) < thr);
    end
  endtask

  // pr[t] is driven during cycle t after the accept edge; the voted sample in
  // cycle n reflects pr[n-2] through the two-flop synchronizer.
  task automatic txn(input logic [9:0] seed, input int hold, input int abort_t);
    logic [9:0] l;
    logic [9:0] ch [RB];
    logic [RB-1:0] ed, eu;
    int ones;
    l = seed == '0 ? 10'd1 : seed;
    for (int k = 0; k < RB; k++) begin
      ch[k] = l;
      ones = 0;
      for (int j = 0; j < 5; j++) ones += int'(pr[PER*k + 18 + j]);
      ed[k] = ones > 2;
      eu[k] = ones != 0 && ones != 5;
      l = {l[8:0], ^(l & 10'h240)};
    end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1;
    req_chal = seed;
    @(negedge clk);
    req_valid = 0;
    for (int t = 0; t < LAT; t++) begin
      puf_resp = pr[t];
      if (t == abort_t) begin
        rst_n = 0;
        #1;
        chk("rst_puf_chal", 32'(puf_chal), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        return;
      end
      chk($sformatf("puf_chal_t%0d", t), 32'(puf_chal), 32'(t % PER < 4 ? 10'd0 : ch[t / PER]));
      chk("rsp_valid_early", 32'(rsp_valid), 32'd0);
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      chk("busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    chk("rsp_valid_latency", 32'(rsp_valid), 32'd1);
    chk("rsp_data", 32'(rsp_data), 32'(ed));
    chk("rsp_unstable", 32'(rsp_unstable), 32'(eu));
    chk("done_puf_chal", 32'(puf_chal), 32'd0);
    chk("done_req_ready", 32'(req_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_data", 32'(rsp_data), 32'(ed));
      chk("hold_rsp_unstable", 32'(rsp_unstable), 32'(eu));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("release_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("release_req_ready", 32'(req_ready), 32'd1);
    chk("retain_rsp_data", 32'(rsp_data), 32'(ed));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_rsp_unstable", 32'(rsp_unstable), 32'd0);
    chk("reset_puf_chal", 32'(puf_chal), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1;
    @(negedge clk);
    fill(1);
    txn(10'h155, 0, -1);
    fill(2);
    txn(10'h000, 3, -1);
    fill(0);
    pr[18] = 1; pr[19] = 0; pr[20] = 1; pr[21] = 1; pr[22] = 0;
    txn(10'h240, 10, -1);
    fill(0);
    pr[18] = 0; pr[19] = 0; pr[20] = 1; pr[21] = 0; pr[22] = 0;
    txn(10'($urandom), 0, -1);
    fill(0);
    txn(10'($urandom), 0, 3 * PER + 10);
    for (int i = 0; i < 4; i++) begin
      fill(0);
      txn(10'($urandom), $urandom_range(0, 5), -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/bpuf_crp_controller.md
Name: bpuf_crp_controller

Overview:
- Sequences one challenge-response exchange on the bistable-ring PUF array (CHAL_W cells, XOR-folded 1-bit output).
- Accepts a seed challenge over a valid/ready handshake and derives RESP_BITS challenges from an internal LFSR.
- For each challenge: clears the rings, excites them, lets them settle, then majority-votes several synchronized samples of the PUF output.
- Returns the RESP_BITS-bit response word and a per-bit instability mask over a second valid/ready handshake.

Parameters:
CHAL_W, 10, challenge width; equals the PUF cell count.
RESP_BITS, 8, response bits produced per request (1..32).
TAPS, 10'h240, Fibonacci LFSR feedback mask (x^10+x^7+1); width CHAL_W.
RST_CYC, 4, cycles puf_chal is held at all-zero before each evaluation (>=1).
SETTLE_CYC, 16, cycles the challenge is applied before sampling starts; includes the 2-cycle sync latency (>=2).
NUM_SAMPLES, 5, samples per bit; must be odd (>=1).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
req_valid  in  1  request present
req_ready  out  1  controller idle, can accept a request
req_chal  in  CHAL_W  seed challenge
puf_chal  out  CHAL_W  excite vector to the PUF cells (registered)
puf_resp  in  1  raw asynchronous PUF output
rsp_valid  out  1  response word available
rsp_ready  in  1  consumer accepts the response
rsp_data  out  RESP_BITS  response word; bit k is the result of challenge k
rsp_unstable  out  RESP_BITS  bit k=1 if the samples for bit k were not unanimous
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; req_ready=1; rsp_valid=0; rsp_data=0; rsp_unstable=0; puf_chal=0; busy=0.
  - LFSR, counters and synchronizer flops are cleared.
- Synchronizer: puf_resp passes through a 2-flop synchronizer. The sampled value is the second flop's output.
- States: IDLE, CLEAR, EXCITE, SAMPLE, DONE.
- IDLE:
  - req_ready=1 and puf_chal=0.
  - On req_valid&&req_ready the LFSR loads req_chal. A seed of zero loads 1 instead.
  - bit_idx=0, rsp_data and rsp_unstable are cleared, and the state moves to CLEAR.
- CLEAR: puf_chal=0 for exactly RST_CYC cycles, then EXCITE.
- EXCITE: puf_chal=LFSR value for SETTLE_CYC cycles, then SAMPLE.
- SAMPLE:
  - puf_chal stays at the LFSR value.
  - For NUM_SAMPLES cycles, one synchronized sample is counted per cycle into ones_cnt.
  - On the last sample cycle: rsp_data[bit_idx] = (ones_cnt_final > NUM_SAMPLES/2), and rsp_unstable[bit_idx] = (ones_cnt_final != 0 && != NUM_SAMPLES).
  - ones_cnt_final includes the sample taken in that same cycle.
- After SAMPLE:
  - If bit_idx==RESP_BITS-1: go to DONE.
  - Otherwise: bit_idx++, LFSR advances, go to CLEAR.
  - LFSR step: next = {lfsr[CHAL_W-2:0], ^(lfsr & TAPS)}.
- DONE:
  - rsp_valid=1; rsp_data and rsp_unstable are held stable; puf_chal=0.
  - On rsp_ready the controller goes to IDLE and rsp_valid falls on the same edge.
  - rsp_data is retained until the next accept.
- Latency: rsp_valid rises exactly RESP_BITS*(RST_CYC+SETTLE_CYC+NUM_SAMPLES) cycles after the accept edge. With defaults that is 200 cycles.
- No new request is accepted until DONE completes; req_ready=0 while busy.
- rsp_valid is held under backpressure indefinitely. Data and flags must not change while rsp_valid=1 and rsp_ready=0.
- Counters: widths sized from their parameters (clog2+1). No wrap is possible within a phase.
- Reset mid-operation returns all outputs to their reset values immediately, including puf_chal=0 so the rings stop being excited. No partial response is ever presented.
- puf_chal only changes on clock edges. It must go through 0 between consecutive challenges; there is never a direct challenge-to-challenge transition.

Test Plan:
- puf_resp tied 1, seed 10'h155 -> rsp_valid high 200 cycles after accept; rsp_data=8'hFF; rsp_unstable=8'h00; req_ready low throughout.
- puf_resp tied 0 -> rsp_data=8'h00 and rsp_unstable=8'h00; puf_chal equals 0 for 4 cycles before each of the 8 excitations.
- Seed 0 -> challenges observed on puf_chal are 0x001, 0x002, 0x004 ... 0x080. Seed 10'h240 -> second challenge 10'h080.
- Bit 0 sample window (after sync) driven 1,0,1,1,0 -> rsp_data[0]=1, rsp_unstable[0]=1. Pattern 0,0,1,0,0 -> rsp_data[0]=0, rsp_unstable[0]=1.
- Hold rsp_ready=0 for 10 cycles in DONE -> rsp_valid, rsp_data and rsp_unstable stable and req_ready=0. Pulse rsp_ready -> IDLE next cycle; a back-to-back req_valid is accepted on the following edge.
- Assert rst_n=0 during EXCITE of bit 3 -> puf_chal=0, rsp_valid=0, busy=0 asynchronously. After release, req_ready=1 and a new request completes normally in 200 cycles.
